// File: rtl/freq_meas_pkg.sv
// Shared constants, FSM state encoding and per-state bus helpers for the
// frequency-counter measurement sequencer.
package freq_meas_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR  = 4'd1,
    S_ARM  = 4'd2,
    S_POLL = 4'd3,
    S_GAP  = 4'd4,
    S_RD_C = 4'd5,
    S_RD_F = 4'd6,
    S_ACKN = 4'd7,
    S_PUSH = 4'd8
  } state_t;

  localparam logic [31:0] CTRL_ADDR   = 32'h8;
  localparam logic [31:0] COARSE_ADDR = 32'h9;
  localparam logic [31:0] FINE_ADDR   = 32'hA;

  localparam int unsigned CTRL_START = 7;
  localparam int unsigned CTRL_DONE  = 6;
  localparam int unsigned CTRL_RST   = 0;

  localparam logic [31:0] CTRL_WR_RST = 32'd1 << CTRL_RST;
  localparam logic [31:0] CTRL_WR_ARM = 32'd1 << CTRL_START;

  // Slave address used by each bus state.
  function automatic logic [31:0] bus_addr(input state_t s);
    case (s)
      S_RD_C:  return COARSE_ADDR;
      S_RD_F:  return FINE_ADDR;
      default: return CTRL_ADDR;
    endcase
  endfunction

  // Bus states that write the control register.
  function automatic logic bus_we(input state_t s);
    return (s == S_CLR) || (s == S_ARM) || (s == S_ACKN);
  endfunction

  // Control-register value written by each write state.
  function automatic logic [31:0] bus_wdata(input state_t s);
    case (s)
      S_CLR:   return CTRL_WR_RST;
      S_ARM:   return CTRL_WR_ARM;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/meas_result_fifo.sv
// First-word fall-through FIFO holding {coarse, fine} count pairs.
module meas_result_fifo #(
  parameter int unsigned DEPTH = 4
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [63:0]                    push_data,
  input  logic                           pop_req,
  output logic                           valid,
  output logic [63:0]                    head,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (level != '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop_req && valid;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/freq_meas_sequencer.sv
// Wishbone master that drives complete vernier measurements on the frequency
// counter and queues the resulting count pairs for the control unit.
module freq_meas_sequencer
  import freq_meas_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned POLL_GAP     = 8,
  parameter logic [31:0] MEAS_TIMEOUT = 32'd1_000_000,
  parameter int unsigned BUS_TIMEOUT  = 16
)(
  input  logic                              clk_i,
  input  logic                              ext_rst_i,
  input  logic                              start_i,
  input  logic                              stop_i,
  input  logic                              continuous_i,
  input  logic                              clear_flags_i,
  output logic [31:0]                       wb_adr_o,
  output logic [31:0]                       wb_dat_o,
  input  logic [31:0]                       wb_dat_i,
  output logic                              wb_we_o,
  output logic [3:0]                        wb_sel_o,
  output logic                              wb_cyc_o,
  output logic                              wb_stb_o,
  input  logic                              wb_ack_i,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [31:0]                       res_coarse_o,
  output logic [31:0]                       res_fine_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
  output logic                              busy_o,
  output logic                              timeout_o,
  output logic                              bus_err_o,
  output logic                              overflow_o,
  output logic [3:0]                        state_o
);

  localparam int unsigned BT_W = $clog2(BUS_TIMEOUT+1);
  localparam int unsigned GP_W = $clog2(POLL_GAP+1);
  localparam logic [BT_W-1:0] BT_LAST  = BT_W'(BUS_TIMEOUT-1);
  localparam logic [GP_W-1:0] GAP_LAST = GP_W'(POLL_GAP-1);

  state_t          state;
  logic [BT_W-1:0] stb_cnt;
  logic [GP_W-1:0] gap_cnt;
  logic [31:0]     poll_cnt;
  logic [31:0]     poll_inc;
  logic            cont;
  logic            stop_pend;
  logic            abort;
  logic [31:0]     coarse;
  logic [31:0]     fine;
  logic            fifo_full;
  logic            pop;
  logic [63:0]     head;

  assign state_o      = state;
  assign busy_o       = (state != S_IDLE);
  assign pop          = res_ready_i && res_valid_o;
  assign res_coarse_o = head[63:32];
  assign res_fine_o   = head[31:0];

  // Saturating next value of the poll counter.
  always_comb begin
    poll_inc = poll_cnt;
    if (poll_cnt != '1) poll_inc = poll_cnt + 32'd1;
  end

  // Sequencer FSM with registered Wishbone outputs and sticky flags.
  always_ff @(posedge clk_i or negedge ext_rst_i) begin
    if (!ext_rst_i) begin
      state     <= S_IDLE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      stb_cnt   <= '0;
      gap_cnt   <= '0;
      poll_cnt  <= '0;
      cont      <= 1'b0;
      stop_pend <= 1'b0;
      abort     <= 1'b0;
      coarse    <= '0;
      fine      <= '0;
      timeout_o <= 1'b0;
      bus_err_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      // Clear first so that a set later in this cycle takes priority.
      if (clear_flags_i) begin
        timeout_o  <= 1'b0;
        bus_err_o  <= 1'b0;
        overflow_o <= 1'b0;
      end
      if (stop_i && state != S_IDLE) stop_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          abort     <= 1'b0;
          if (start_i) begin
            cont  <= continuous_i;
            state <= S_CLR;
          end
        end

        S_CLR, S_ARM, S_POLL, S_RD_C, S_RD_F, S_ACKN: begin
          if (!wb_stb_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_sel_o <= '1;
            wb_adr_o <= bus_addr(state);
            wb_we_o  <= bus_we(state);
            wb_dat_o <= bus_wdata(state);
            stb_cnt  <= '0;
          // stb_cnt == 0 marks the first strobe cycle, where ack may be stale.
          end else if (stb_cnt != '0 && wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= '0;
            wb_adr_o <= '0;
            wb_we_o  <= 1'b0;
            wb_dat_o <= '0;
            case (state)
              S_CLR: begin
                if (abort) begin
                  abort     <= 1'b0;
                  stop_pend <= 1'b0;
                  state     <= S_IDLE;
                end else begin
                  state <= S_ARM;
                end
              end
              S_ARM: begin
                poll_cnt <= '0;
                state    <= S_POLL;
              end
              S_POLL: begin
                if (wb_dat_i[CTRL_DONE]) begin
                  state <= S_RD_C;
                end else begin
                  poll_cnt <= poll_inc;
                  if (poll_inc >= MEAS_TIMEOUT) begin
                    timeout_o <= 1'b1;
                    abort     <= 1'b1;
                    state     <= S_CLR;
                  end else begin
                    gap_cnt <= '0;
                    state   <= S_GAP;
                  end
                end
              end
              S_RD_C: begin
                coarse <= wb_dat_i;
                state  <= S_RD_F;
              end
              S_RD_F: begin
                fine  <= wb_dat_i;
                state <= S_ACKN;
              end
              default: state <= S_PUSH;
            endcase
          end else if (stb_cnt == BT_LAST) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_sel_o  <= '0;
            wb_adr_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_dat_o  <= '0;
            bus_err_o <= 1'b1;
            abort     <= 1'b0;
            stop_pend <= 1'b0;
            state     <= S_IDLE;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_POLL;
          else gap_cnt <= gap_cnt + 1'b1;
        end

        S_PUSH: begin
          if (fifo_full && !pop) overflow_o <= 1'b1;
          if (cont && !stop_pend && !stop_i) begin
            state <= S_CLR;
          end else begin
            stop_pend <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  meas_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (ext_rst_i),
    .push      (state == S_PUSH),
    .push_data ({coarse, fine}),
    .pop_req   (res_ready_i),
    .valid     (res_valid_o),
    .head      (head),
    .full      (fifo_full),
    .level     (fifo_level_o)
  );

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed bench for freq_meas_sequencer with a behavioural counter slave.
module tb_freq_meas_sequencer;
  import freq_meas_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH+1);

  logic          clk_i = 1'b0;
  logic          ext_rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          continuous_i = 1'b0;
  logic          clear_flags_i = 1'b0;
  logic [31:0]   wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_ack_i;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [31:0]   res_coarse_o;
  logic [31:0]   res_fine_o;
  logic [LW-1:0] fifo_level_o;
  logic          busy_o;
  logic          timeout_o;
  logic          bus_err_o;
  logic          overflow_o;
  logic [3:0]    state_o;

  always #5 clk_i = ~clk_i;

  freq_meas_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .POLL_GAP     (2),
    .MEAS_TIMEOUT (32'd5),
    .BUS_TIMEOUT  (16)
  ) dut (
    .clk_i         (clk_i),
    .ext_rst_i     (ext_rst_i),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .continuous_i  (continuous_i),
    .clear_flags_i (clear_flags_i),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_dat_i      (wb_dat_i),
    .wb_we_o       (wb_we_o),
    .wb_sel_o      (wb_sel_o),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_ack_i      (wb_ack_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_coarse_o  (res_coarse_o),
    .res_fine_o    (res_fine_o),
    .fifo_level_o  (fifo_level_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .bus_err_o     (bus_err_o),
    .overflow_o    (overflow_o),
    .state_o       (state_o)
  );

  // ---------------- counter slave model ----------------
  int unsigned ack_mode  = 0;   // 0 registered ack, 1 stuck high, 2 stuck low
  int unsigned done_poll = 0;   // poll number that first reports done, 0 = never
  logic [31:0] coarse_base = '0;
  logic [31:0] fine_base   = '0;
  logic        stats_clr   = 1'b1;

  logic        ack_r = 1'b0;
  logic        accept;
  logic [31:0] rd_data;
  int unsigned run = 0, last_len = 0, min_len = 0, max_len = 0, n_xfer = 0;
  int unsigned n_wr = 0, n_bad = 0, n_poll = 0, n_ackn = 0, meas_idx = 0, poll_in_meas = 0;
  logic [31:0] wr_log [16];

  assign wb_ack_i = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'b0 : ack_r;
  assign accept   = wb_cyc_o && wb_stb_o && wb_ack_i && (run != 0);
  assign wb_dat_i = rd_data;

  // Read data is garbage in the first strobe cycle, real from the second on.
  always_comb begin
    rd_data = '1;
    if (run != 0) begin
      case (wb_adr_o)
        32'h8:   rd_data = (done_poll != 0 && poll_in_meas + 1 >= done_poll) ? 32'h40 : 32'h80;
        32'h9:   rd_data = coarse_base + meas_idx;
        32'hA:   rd_data = fine_base + meas_idx;
        default: rd_data = '0;
      endcase
    end
  end

  // Slave handshake and transaction log.
  always @(posedge clk_i) begin
    if (!ext_rst_i || stats_clr) begin
      ack_r <= 1'b0;
      run   <= 0;
      if (stats_clr) begin
        last_len <= 0; min_len <= 99; max_len <= 0; n_xfer <= 0; n_wr <= 0;
        n_bad <= 0; n_poll <= 0; n_ackn <= 0; meas_idx <= 0; poll_in_meas <= 0;
      end
    end else if (wb_cyc_o && wb_stb_o) begin
      ack_r <= !ack_r;
      if (accept) begin
        run      <= 0;
        last_len <= run + 1;
        n_xfer   <= n_xfer + 1;
        if (run + 1 < min_len) min_len <= run + 1;
        if (run + 1 > max_len) max_len <= run + 1;
        if (wb_we_o) begin
          if (n_wr < 16) wr_log[4'(n_wr)] <= wb_dat_o;
          n_wr <= n_wr + 1;
          if (wb_adr_o != 32'h8) n_bad <= n_bad + 1;
          if (wb_dat_o == 32'h1) poll_in_meas <= 0;
          if (wb_dat_o == 32'h0) begin
            n_ackn   <= n_ackn + 1;
            meas_idx <= meas_idx + 1;
          end
        end else if (wb_adr_o == 32'h8) begin
          n_poll       <= n_poll + 1;
          poll_in_meas <= poll_in_meas + 1;
        end
      end else begin
        run <= run + 1;
      end
    end else begin
      ack_r <= 1'b0;
      if (run != 0) begin
        last_len <= run;
        run      <= 0;
      end
    end
  end

  // ---------------- checking ----------------
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] c, input logic [31:0] f);
    chk({tag, "_valid"}, 64'(res_valid_o), 64'd1);
    chk({tag, "_data"}, {res_coarse_o, res_fine_o}, {c, f});
  endtask

  task automatic pulse_start(input logic cont);
    @(negedge clk_i);
    continuous_i = cont;
    start_i      = 1'b1;
    @(negedge clk_i);
    start_i      = 1'b0;
    continuous_i = 1'b0;
  endtask

  task automatic clear_stats();
    @(negedge clk_i);
    stats_clr = 1'b1;
    @(negedge clk_i);
    stats_clr = 1'b0;
  endtask

  task automatic clear_flags();
    @(negedge clk_i);
    clear_flags_i = 1'b1;
    @(negedge clk_i);
    clear_flags_i = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk_i);
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while (busy_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned strobes;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
    chk("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'd0);
    chk("rst_res", {res_coarse_o, res_fine_o}, 64'd0);
    chk("rst_status", 64'({res_valid_o, fifo_level_o, busy_o, timeout_o, bus_err_o, overflow_o}), 64'd0);
    chk("rst_state", 64'(state_o), 64'(S_IDLE));
    ext_rst_i = 1'b1;
    stats_clr = 1'b0;

    // Single shot, done on the 3rd poll
    done_poll = 3; coarse_base = 32'h1234; fine_base = 32'h42; ack_mode = 0;
    clear_stats();
    pulse_start(1'b0);
    chk("t1_gap_cyc", 64'(wb_cyc_o), 64'd0);
    @(negedge clk_i);
    chk("t1_clr_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}),
        64'({1'b1, 1'b1, 1'b1, 4'hF, 32'h8, 32'h1}));
    wait_idle("t1");
    chk("t1_nwr", 64'(n_wr), 64'd3);
    chk("t1_wr0", 64'(wr_log[0]), 64'h01);
    chk("t1_wr1", 64'(wr_log[1]), 64'h80);
    chk("t1_wr2", 64'(wr_log[2]), 64'h00);
    chk("t1_wr_addr", 64'(n_bad), 64'd0);
    chk("t1_polls", 64'(n_poll), 64'd3);
    chk("t1_len", 64'({min_len[7:0], max_len[7:0]}), 64'h0202);
    check_head("t1_head", 32'h1234, 32'h42);
    chk("t1_level", 64'(fifo_level_o), 64'd1);
    pop_one();
    chk("t1_level_pop", 64'(fifo_level_o), 64'd0);

    // Stale ack: ack held high throughout
    ack_mode = 1; done_poll = 1; coarse_base = 32'h5555_0001; fine_base = 32'h77;
    clear_stats();
    pulse_start(1'b0);
    wait_idle("t2");
    chk("t2_nxfer", 64'(n_xfer), 64'd6);
    chk("t2_len", 64'({min_len[7:0], max_len[7:0]}), 64'h0202);
    check_head("t2_head", 32'h5555_0001, 32'h77);
    pop_one();
    ack_mode = 0;

    // Continuous, consumer stalled, six measurements
    done_poll = 3; coarse_base = 32'h100; fine_base = 32'h10;
    clear_stats();
    pulse_start(1'b1);
    n = 0;
    while (n_ackn < 5 && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk("t3_five_meas", 64'(n_ackn), 64'd5);
    repeat (10) @(negedge clk_i);
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
    wait_idle("t3");
    chk("t3_meas", 64'(n_ackn), 64'd6);
    chk("t3_level", 64'(fifo_level_o), 64'd4);
    chk("t3_overflow", 64'(overflow_o), 64'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      check_head("t3_head", 32'(32'h100 + i), 32'(32'h10 + i));
      pop_one();
    end
    chk("t3_empty", 64'({res_valid_o, fifo_level_o}), 64'd0);
    pop_one();
    chk("t3_pop_empty", 64'(fifo_level_o), 64'd0);
    clear_flags();
    chk("t3_ovf_clr", 64'(overflow_o), 64'd0);

    // Measurement timeout: done never set
    done_poll = 0;
    clear_stats();
    pulse_start(1'b0);
    wait_idle("t4");
    chk("t4_timeout", 64'(timeout_o), 64'd1);
    chk("t4_polls", 64'(n_poll), 64'd5);
    chk("t4_nwr", 64'(n_wr), 64'd3);
    chk("t4_wr1", 64'(wr_log[1]), 64'h80);
    chk("t4_wr2", 64'(wr_log[2]), 64'h01);
    chk("t4_no_ackn", 64'(n_ackn), 64'd0);
    chk("t4_level", 64'(fifo_level_o), 64'd0);
    clear_flags();
    chk("t4_to_clr", 64'(timeout_o), 64'd0);

    // Bus timeout: ack stuck low
    ack_mode = 2;
    clear_stats();
    pulse_start(1'b0);
    n = 0;
    strobes = 0;
    while (!bus_err_o && n < 100) begin
      if (wb_stb_o) strobes++;
      @(negedge clk_i);
      n++;
    end
    chk("t5_bus_err", 64'(bus_err_o), 64'd1);
    chk("t5_strobes", 64'(strobes), 64'd16);
    chk("t5_dropped", 64'({wb_cyc_o, wb_stb_o, busy_o}), 64'd0);
    chk("t5_state", 64'(state_o), 64'(S_IDLE));
    @(negedge clk_i);
    chk("t5_len", 64'(last_len), 64'd16);
    ack_mode = 0;
    clear_flags();
    chk("t5_err_clr", 64'(bus_err_o), 64'd0);

    // Asynchronous reset during RD_F, FIFO holding an older result
    done_poll = 1; coarse_base = 32'hA000; fine_base = 32'hB0;
    clear_stats();
    pulse_start(1'b0);
    wait_idle("t6a");
    chk("t6_level_pre", 64'(fifo_level_o), 64'd1);
    pulse_start(1'b0);
    n = 0;
    while (!(state_o == S_RD_F && wb_stb_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("t6_in_rdf", 64'({state_o, wb_stb_o}), 64'({S_RD_F, 1'b1}));
    #2 ext_rst_i = 1'b0;
    #1;
    chk("t6_rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'd0);
    chk("t6_rst_adr", 64'(wb_adr_o), 64'd0);
    chk("t6_rst_fifo", 64'({res_valid_o, fifo_level_o, busy_o}), 64'd0);
    chk("t6_rst_head", {res_coarse_o, res_fine_o}, 64'd0);
    chk("t6_rst_state", 64'(state_o), 64'(S_IDLE));
    repeat (2) @(negedge clk_i);
    ext_rst_i = 1'b1;
    coarse_base = 32'hC000; fine_base = 32'hC1;
    clear_stats();
    pulse_start(1'b0);
    wait_idle("t6b");
    check_head("t6_head", 32'hC000, 32'hC1);
    chk("t6_level", 64'(fifo_level_o), 64'd1);
    chk("t6_nwr", 64'(n_wr), 64'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
